// File: rtl/operand_fetch.sv
`default_nettype none
// ============================================================================
// Module   : operand_fetch
// Brief    : Operand fetch stage with scoreboard hazard stall, writeback
//            bypass and a registered valid/ready output towards execute.
// Revision : 1.0 - initial release
// ============================================================================
module operand_fetch #(
    parameter int DW  = 16,
    parameter int AW  = 3,
    parameter int OPW = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [OPW-1:0] in_op,
    input  logic [AW-1:0]  in_rs1,
    input  logic [AW-1:0]  in_rs2,
    input  logic           in_use_rs1,
    input  logic           in_use_rs2,
    input  logic [AW-1:0]  in_rd,
    input  logic           in_wr_en,
    input  logic [DW-1:0]  in_imm,
    input  logic           in_use_imm,
    output logic [AW-1:0]  reg_read_addr_1,
    output logic [AW-1:0]  reg_read_addr_2,
    input  logic [DW-1:0]  reg_read_data_1,
    input  logic [DW-1:0]  reg_read_data_2,
    input  logic           wb_en,
    input  logic [AW-1:0]  wb_dest,
    input  logic [DW-1:0]  wb_data,
    input  logic           flush,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [OPW-1:0] out_op,
    output logic [DW-1:0]  out_a,
    output logic [DW-1:0]  out_b,
    output logic [AW-1:0]  out_rd,
    output logic           out_wr_en
);

    localparam int NREG = 2 ** AW;

    logic [NREG-1:0] r_busy;
    logic            r_out_valid;
    logic [OPW-1:0]  r_out_op;
    logic [DW-1:0]   r_out_a;
    logic [DW-1:0]   r_out_b;
    logic [AW-1:0]   r_out_rd;
    logic            r_out_wr_en;

    logic [NREG-1:0] w_wb_clr;
    logic [NREG-1:0] w_fl_clr;
    logic [NREG-1:0] w_set;
    logic [NREG-1:0] w_eb;
    logic [NREG-1:0] w_busy_nxt;
    logic            w_hazard;
    logic            w_accept;
    logic [DW-1:0]   w_opa;
    logic [DW-1:0]   w_opb;

    assign reg_read_addr_1 = in_rs1;
    assign reg_read_addr_2 = in_rs2;

    // A register being written back this cycle is no longer a hazard.
    assign w_eb = r_busy & ~w_wb_clr;

    assign w_hazard = (in_use_rs1 && (in_rs1 != '0) && w_eb[in_rs1])
                   || (in_use_rs2 && !in_use_imm && (in_rs2 != '0) && w_eb[in_rs2])
                   || (in_wr_en && (in_rd != '0) && w_eb[in_rd]);

    assign in_ready = !w_hazard && (!r_out_valid || out_ready) && !flush;
    assign w_accept = in_valid && in_ready;

    always_comb begin
        w_wb_clr = '0;
        w_fl_clr = '0;
        w_set    = '0;
        for (int i = 0; i < NREG; i++) begin
            w_wb_clr[i] = wb_en && (wb_dest == AW'(i));
            w_fl_clr[i] = flush && r_out_valid && r_out_wr_en && (r_out_rd == AW'(i));
            w_set[i]    = w_accept && in_wr_en && (in_rd == AW'(i));
        end
    end

    // Set wins over any clear; r0 never becomes busy.
    assign w_busy_nxt = (r_busy & ~w_wb_clr & ~w_fl_clr) | w_set;

    // The register file write is not visible until next cycle, so bypass wb_data.
    always_comb begin
        w_opa = reg_read_data_1;
        if (in_rs1 == '0)
            w_opa = '0;
        else if (wb_en && (wb_dest == in_rs1))
            w_opa = wb_data;

        w_opb = reg_read_data_2;
        if (in_use_imm)
            w_opb = in_imm;
        else if (in_rs2 == '0)
            w_opb = '0;
        else if (wb_en && (wb_dest == in_rs2))
            w_opb = wb_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy      <= '0;
            r_out_valid <= 1'b0;
            r_out_op    <= '0;
            r_out_a     <= '0;
            r_out_b     <= '0;
            r_out_rd    <= '0;
            r_out_wr_en <= 1'b0;
        end else begin
            r_busy <= {w_busy_nxt[NREG-1:1], 1'b0};
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_op    <= in_op;
                r_out_a     <= w_opa;
                r_out_b     <= w_opb;
                r_out_rd    <= in_rd;
                r_out_wr_en <= in_wr_en;
            end else if (flush || out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_op    = r_out_op;
    assign out_a     = r_out_a;
    assign out_b     = r_out_b;
    assign out_rd    = r_out_rd;
    assign out_wr_en = r_out_wr_en;

endmodule
`default_nettype wire

// File: tb/tb_operand_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_operand_fetch
// Brief    : Directed self-checking bench for operand_fetch.
// Revision : 1.0 - initial release
// ============================================================================
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [2:0]  in_rs1, in_rs2;
    logic        in_use_rs1, in_use_rs2;
    logic [2:0]  in_rd;
    logic        in_wr_en;
    logic [15:0] in_imm;
    logic        in_use_imm;
    logic [2:0]  reg_read_addr_1, reg_read_addr_2;
    logic [15:0] reg_read_data_1, reg_read_data_2;
    logic        wb_en;
    logic [2:0]  wb_dest;
    logic [15:0] wb_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_op;
    logic [15:0] out_a, out_b;
    logic [2:0]  out_rd;
    logic        out_wr_en;

    int n_tests = 0;
    int n_fail  = 0;

    operand_fetch #(.DW(16), .AW(3), .OPW(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
        .in_rd(in_rd), .in_wr_en(in_wr_en),
        .in_imm(in_imm), .in_use_imm(in_use_imm),
        .reg_read_addr_1(reg_read_addr_1), .reg_read_addr_2(reg_read_addr_2),
        .reg_read_data_1(reg_read_data_1), .reg_read_data_2(reg_read_data_2),
        .wb_en(wb_en), .wb_dest(wb_dest), .wb_data(wb_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_a(out_a), .out_b(out_b),
        .out_rd(out_rd), .out_wr_en(out_wr_en)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        in_valid = 0; in_op = 0; in_rs1 = 0; in_rs2 = 0;
        in_use_rs1 = 0; in_use_rs2 = 0; in_rd = 0; in_wr_en = 0;
        in_imm = 0; in_use_imm = 0;
        reg_read_data_1 = 0; reg_read_data_2 = 0;
        wb_en = 0; wb_dest = 0; wb_data = 0; flush = 0;
    endtask

    initial begin
        clr_in();
        out_ready = 0;
        rst = 1;
        step();
        step();
        check_val("rst_out_valid", {31'd0, out_valid}, 0);
        check_val("rst_out_a", {16'd0, out_a}, 0);
        check_val("rst_busy", {24'd0, dut.r_busy}, 0);
        rst = 0;

        // Basic issue: r3 = f(r1, r2)
        in_valid = 1; in_op = 4'd5; in_rs1 = 1; in_rs2 = 2;
        in_use_rs1 = 1; in_use_rs2 = 1; in_rd = 3; in_wr_en = 1;
        reg_read_data_1 = 16'h1111; reg_read_data_2 = 16'h2222;
        #1;
        check_val("basic_in_ready", {31'd0, in_ready}, 1);
        check_val("basic_addr1", {29'd0, reg_read_addr_1}, 1);
        check_val("basic_addr2", {29'd0, reg_read_addr_2}, 2);
        step();
        check_val("basic_out_valid", {31'd0, out_valid}, 1);
        check_val("basic_out_a", {16'd0, out_a}, 32'h1111);
        check_val("basic_out_b", {16'd0, out_b}, 32'h2222);
        check_val("basic_out_op", {28'd0, out_op}, 5);
        check_val("basic_out_rd", {29'd0, out_rd}, 3);
        check_val("basic_busy", {24'd0, dut.r_busy}, 32'h08);

        // RAW stall on r3, then release by writeback with bypass
        clr_in();
        out_ready = 1;
        in_valid = 1; in_rs1 = 3; in_use_rs1 = 1; in_use_rs2 = 1; in_rs2 = 0;
        reg_read_data_1 = 16'hAAAA;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_val("raw_stall_ready", {31'd0, in_ready}, 0);
            step();
        end
        check_val("raw_bubble_valid", {31'd0, out_valid}, 0);
        wb_en = 1; wb_dest = 3; wb_data = 16'hBEEF;
        #1;
        check_val("raw_release_ready", {31'd0, in_ready}, 1);
        step();
        wb_en = 0;
        check_val("raw_bypass_a", {16'd0, out_a}, 32'hBEEF);
        check_val("raw_rs2_zero_b", {16'd0, out_b}, 0);
        check_val("raw_busy_clr", {24'd0, dut.r_busy}, 0);

        // r0 reads as zero despite bypass/regfile; r0 write never sets busy
        clr_in();
        in_valid = 1; in_rs1 = 0; in_use_rs1 = 1; reg_read_data_1 = 16'hFFFF;
        wb_en = 1; wb_dest = 0; wb_data = 16'h1234;
        in_rd = 0; in_wr_en = 1; in_use_imm = 1; in_imm = 16'h00C3;
        step();
        check_val("r0_out_a", {16'd0, out_a}, 0);
        check_val("r0_out_b_imm", {16'd0, out_b}, 32'h00C3);
        check_val("r0_busy", {24'd0, dut.r_busy}, 0);

        // Backpressure: X accepted, then held 3 cycles while Y waits
        clr_in();
        in_valid = 1; in_op = 4'd9; in_rs1 = 1; in_use_rs1 = 1;
        reg_read_data_1 = 16'h0101; in_use_imm = 1; in_imm = 16'h7777;
        in_rd = 6; in_wr_en = 1;
        step();
        out_ready = 0;
        in_op = 4'd10; in_rs1 = 2; reg_read_data_1 = 16'h0202;
        in_imm = 16'h8888; in_rd = 7;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_val("bp_in_ready", {31'd0, in_ready}, 0);
            check_val("bp_out_valid", {31'd0, out_valid}, 1);
            check_val("bp_out_a", {16'd0, out_a}, 32'h0101);
            check_val("bp_out_b", {16'd0, out_b}, 32'h7777);
            check_val("bp_out_rd", {29'd0, out_rd}, 6);
            step();
        end
        out_ready = 1;
        #1;
        check_val("b2b_in_ready", {31'd0, in_ready}, 1);
        step();
        check_val("b2b_out_valid", {31'd0, out_valid}, 1);
        check_val("b2b_out_a", {16'd0, out_a}, 32'h0202);
        check_val("b2b_out_b", {16'd0, out_b}, 32'h8888);
        check_val("b2b_out_op", {28'd0, out_op}, 10);
        check_val("b2b_busy", {24'd0, dut.r_busy}, 32'hC0);

        // WAW on r5: second writer waits, accepted in clear cycle, set wins
        clr_in();
        in_valid = 1; in_rd = 5; in_wr_en = 1;
        step();
        check_val("waw_busy_a", {24'd0, dut.r_busy}, 32'hE0);
        for (int i = 0; i < 2; i++) begin
            #1;
            check_val("waw_stall_ready", {31'd0, in_ready}, 0);
            step();
        end
        wb_en = 1; wb_dest = 5; wb_data = 16'h5555;
        #1;
        check_val("waw_release_ready", {31'd0, in_ready}, 1);
        step();
        wb_en = 0;
        check_val("waw_out_valid", {31'd0, out_valid}, 1);
        check_val("waw_set_wins", {24'd0, dut.r_busy}, 32'hE0);

        // Flush of a writer to r4, with a same-cycle wb clear of r4
        clr_in();
        in_valid = 1; in_op = 4'd3; in_rs1 = 1; in_use_rs1 = 1;
        reg_read_data_1 = 16'h4444; in_rd = 4; in_wr_en = 1;
        step();
        check_val("fl_pre_busy", {24'd0, dut.r_busy}, 32'hF0);
        check_val("fl_pre_rd", {29'd0, out_rd}, 4);
        in_rd = 1; flush = 1; wb_en = 1; wb_dest = 4;
        #1;
        check_val("fl_in_ready", {31'd0, in_ready}, 0);
        step();
        flush = 0; wb_en = 0;
        check_val("fl_out_valid", {31'd0, out_valid}, 0);
        check_val("fl_busy", {24'd0, dut.r_busy}, 32'hE0);

        // Reset in the middle of a RAW stall on r5
        clr_in();
        in_valid = 1; in_rs1 = 5; in_use_rs1 = 1;
        #1;
        check_val("rst_stall_ready", {31'd0, in_ready}, 0);
        rst = 1;
        step();
        check_val("rst2_out_valid", {31'd0, out_valid}, 0);
        check_val("rst2_out_a", {16'd0, out_a}, 0);
        check_val("rst2_out_op", {28'd0, out_op}, 0);
        check_val("rst2_out_rd", {29'd0, out_rd}, 0);
        check_val("rst2_out_wr_en", {31'd0, out_wr_en}, 0);
        check_val("rst2_busy", {24'd0, dut.r_busy}, 0);
        rst = 0;
        #1;
        check_val("rst2_ready", {31'd0, in_ready}, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Pipeline stage directly upstream of the 8x16 register file.
- Takes decoded instructions, drives the register file's two read addresses, and forwards same-cycle writeback data.
- Tracks pending destination registers in an 8-bit scoreboard and stalls on RAW/WAW hazards.
- Registers fully resolved operands for the execute stage over a valid/ready handshake.

Parameters:
- DW, 16, data width.
- AW, 3, register address width; register count = 2**AW.
- OPW, 4, opcode width passed through.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset; sampled on rising edge of clk.
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  stage accepts instruction this cycle.
- in_op  in  OPW  opcode, passed through.
- in_rs1, in_rs2  in  AW  source register addresses.
- in_use_rs1, in_use_rs2  in  1  source actually read (hazard check enable).
- in_rd  in  AW  destination register.
- in_wr_en  in  1  instruction writes in_rd.
- in_imm  in  DW  immediate.
- in_use_imm  in  1  operand B = in_imm instead of rs2.
- reg_read_addr_1, reg_read_addr_2  out  AW  to register file; combinational copies of in_rs1/in_rs2.
- reg_read_data_1, reg_read_data_2  in  DW  from register file (combinational read).
- wb_en, wb_dest, wb_data  in  1/AW/DW  writeback port, same signals driving the register file write port.
- flush  in  1  kill the output-register instruction.
- out_valid  out  1  operands valid.
- out_ready  in  1  execute stage accepts.
- out_op, out_a, out_b, out_rd, out_wr_en  out  OPW/DW/DW/AW/1  registered payload.

Behaviour:
- Reset: out_valid=0, out_a=out_b=0, out_op=0, out_rd=0, out_wr_en=0, busy[7:0]=0. Reset overrides all other same-cycle events.
- Scoreboard busy[r]:
  - Set on accept when in_wr_en && in_rd!=0.
  - Cleared when wb_en && wb_dest==r.
  - Same-cycle set and clear of one register: set wins.
  - busy[0] is always 0.
- Effective busy this cycle: eb[r] = busy[r] && !(wb_en && wb_dest==r).
- hazard =
  - (in_use_rs1 && in_rs1!=0 && eb[in_rs1]), or
  - (in_use_rs2 && !in_use_imm && in_rs2!=0 && eb[in_rs2]), or
  - (in_wr_en && in_rd!=0 && eb[in_rd]) (WAW).
- Operand A:
  - rs1==0 gives 0.
  - Else if wb_en && wb_dest==rs1, gives wb_data (bypass; the register file write is not yet visible).
  - Else reg_read_data_1.
- Operand B: in_use_imm gives in_imm; otherwise the same rule as A using rs2 and reg_read_data_2.
- in_ready = !hazard && (!out_valid || out_ready) && !flush. Combinational; may depend on in_* fields.
- Accept = in_valid && in_ready. Payload is captured into the output register on the following edge, giving 1-cycle latency.
- If out_valid && out_ready and there is no accept, out_valid goes to 0 next cycle.
- Output payload holds stable while out_valid && !out_ready.
- flush:
  - out_valid goes to 0 next cycle; no accept that cycle.
  - If out_valid && out_wr_en, busy[out_rd] is cleared. This clear takes priority over a same-cycle wb clear; both give 0.
- Unused sources (in_use_*=0) never stall.
- In-flight writers per register: at most one, guaranteed by the WAW stall.

Test Plan:
- Reset, then issue op with rs1=1, rs2=2, rd=3; regfile returns 0x1111/0x2222 -> next cycle out_valid=1, out_a=0x1111, out_b=0x2222, busy[3]=1.
- Issue reader of r3 while busy[3]=1 and wb_en=0 -> in_ready=0 for every stall cycle. Then pulse wb_en, wb_dest=3, wb_data=0xBEEF -> accepted that cycle, out_a=0xBEEF, busy[3]=0.
- rs1=0 while regfile drives 0xFFFF, and wb_en with wb_dest=0, wb_data=0x1234 -> out_a=0x0000. in_rd=0 with in_wr_en -> busy unchanged.
- Hold out_ready=0 with out_valid=1 -> in_ready=0 and out_* unchanged across 3 cycles. Raise out_ready with a new input pending -> back-to-back transfer with no bubble.
- Two writers to r5 in a row -> second stalls until wb_dest=5. Accept the second in the same cycle as the clear -> busy[5]=1 afterward (set wins).
- flush while out_valid=1, out_rd=4, out_wr_en=1 -> out_valid=0 next cycle, busy[4]=0. Assert rst mid-stall -> all outputs and busy return to 0 on the next edge.
